det3_seq: RTL and testbench
===========================

Name: det3_seq

Overview:
- Computes the determinant of a 3x3 matrix of 4-bit unsigned entries by cofactor expansion along row 0.
- Time-shares one instance of the team's existing combinational 2x2 determinant unit, det2, across the three minors.
- Sits above det2 as its sequencer. It captures the matrix on start, runs three minor cycles, accumulates pivot times signed minor, and presents magnitude plus sign in the same format det2 uses.

Parameters:
- ENTRY_W, 4, width of each matrix entry; fixed by det2; must stay 4.
- MAG_W, 14, result magnitude width; worst case is 3*15*225 = 10125 < 2^14.
- ACC_W, 15, internal two's-complement accumulator width (MAG_W+1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin a computation; sampled only in IDLE
- mat  in  36  matrix; entry mRC at bits [4*(3R+C)+3 : 4*(3R+C)], LSB-first
- busy  out  1  high while a computation is in flight
- done  out  1  one-cycle pulse when det_mag/det_sign are updated
- det_mag  out  14  |det|, unsigned
- det_sign  out  1  1 = negative; always 0 when det_mag == 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, det_mag=0, det_sign=0.
  - Matrix register and accumulator cleared.
  - Reset mid-operation aborts the computation; no done pulse is produced.
- States: IDLE, MIN0, MIN1, MIN2, FIN.
- IDLE:
  - busy=0.
  - If start=1 at edge T: capture mat into an internal register, clear acc, go to MIN0.
  - Changes on mat after T are ignored until the next accepted start.
- MIN0 / MIN1 / MIN2: busy=1. Each state drives det2 operands (a,b,c,d) from the captured register:
  - MIN0: (m11, m12, m21, m22), pivot m00, cofactor sign +.
  - MIN1: (m10, m12, m20, m22), pivot m01, cofactor sign -.
  - MIN2: (m10, m11, m20, m21), pivot m02, cofactor sign +.
- det2 convention:
  - Each operand is 4 bits, bit 0 on the a0/b0/c0/d0 pin.
  - Result = a*d - b*c, given as 8-bit magnitude (out1 = LSB) plus sign.
- Per minor state:
  - prod = pivot * minor_mag, a 12-bit unsigned combinational 4x8 multiply.
  - Effective sign = det2 sign XOR cofactor sign.
  - acc += prod or acc -= prod according to effective sign.
  - Advance one state per cycle: MIN0 -> MIN1 -> MIN2 -> FIN.
- FIN:
  - busy=1.
  - Register det_sign = acc[ACC_W-1] and det_mag = |acc| (low 14 bits); if acc==0, sign=0.
  - Assert done for exactly this one cycle, then return to IDLE.
- Latency:
  - start sampled at edge T.
  - done and new outputs valid in the cycle after edge T+4; busy high T+1..T+4.
  - Back-to-back: start at edge T+5 is accepted, giving 5 cycles per determinant.
- start while busy is ignored, with no queuing; start held high in IDLE re-triggers each time the FSM returns to IDLE.
- det_mag/det_sign hold their value between computations; they change only in FIN or on reset.
- Overflow is impossible by width; no saturation logic.

Decomposition:
- Shared package det_pkg:
  - State encoding constants: IDLE, MIN0, MIN1, MIN2, FIN.
  - ENTRY_W, MAG_W, ACC_W.
  - The cofactor sign table {+,-,+}.
  - The entry index helper 4*(3R+C).
- Sub-module: one instance of det2, reused unchanged.
- Multiplier and accumulator stay inline in det3_seq.

Test Plan:
1. Identity: mat = diag(1,1,1), start pulse -> done 5 cycles after start edge; det_mag=1, det_sign=0; busy high exactly 4 cycles.
2. Upper triangular [[15,15,15],[0,15,15],[0,0,15]] -> det_mag=3375, det_sign=0. Then [[0,15,15],[15,15,15],[0,0,15]] -> det_mag=3375, det_sign=1.
3. Singular [[2,0,1],[1,3,2],[1,1,1]] -> det_mag=0, det_sign=0. Also [[0,15,15],[15,0,15],[15,15,0]] -> det_mag=6750, det_sign=0.
4. Capture and ignore:
   - Start with identity, then change mat and pulse start during MIN1 -> result 1.
   - Exactly one done; no second computation begins.
5. Reset mid-operation: assert rst during MIN2 -> next cycle busy=0, done=0, det_mag=0, det_sign=0; no done pulse ever appears for the aborted run.
6. Back-to-back: start held high across two runs (diag(2,2,2) then [[3,0,0],[0,3,0],[0,0,3]]) -> done at cycles 5 and 10, results 8 then 27.

Source files
------------

// File: rtl/det3_seq_pkg.sv
// Shared definitions for the 3x3 determinant sequencer: widths, FSM states,
// cofactor sign table and the matrix entry index helper.
package det_pkg;

    localparam int ENTRY_W = 4;
    localparam int MAG_W   = 14;
    localparam int ACC_W   = MAG_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MIN0 = 3'd1,
        MIN1 = 3'd2,
        MIN2 = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Bit i set means the cofactor for column i of row 0 is negative: {+,-,+}.
    localparam logic [2:0] COF_NEG = 3'b010;

    function automatic int unsigned entry_idx(input int unsigned r, input int unsigned c);
        return 4 * (3 * r + c);
    endfunction

endpackage

// File: rtl/det3_seq_det2.sv
// Combinational 2x2 determinant a*d - b*c on 4-bit unsigned operands,
// returned as an 8-bit magnitude (out1 = LSB) plus a sign bit.
module det2 (
    input  logic a0, a1, a2, a3,
    input  logic b0, b1, b2, b3,
    input  logic c0, c1, c2, c3,
    input  logic d0, d1, d2, d3,
    output logic out1, out2, out3, out4, out5, out6, out7, out8,
    output logic sign
);

    logic [3:0] a, b, c, d;
    logic [7:0] ad, bc;
    logic [8:0] diff;
    logic [7:0] mag;

    assign a = {a3, a2, a1, a0};
    assign b = {b3, b2, b1, b0};
    assign c = {c3, c2, c1, c0};
    assign d = {d3, d2, d1, d0};

    assign ad   = {4'b0, a} * {4'b0, d};
    assign bc   = {4'b0, b} * {4'b0, c};
    assign diff = {1'b0, ad} - {1'b0, bc};

    // |a*d - b*c| never exceeds 225, so 8 bits of magnitude always suffice.
    always_comb begin
        mag = diff[8] ? (8'd0 - diff[7:0]) : diff[7:0];
    end

    assign {out8, out7, out6, out5, out4, out3, out2, out1} = mag;
    assign sign = diff[8];

endmodule

// File: rtl/det3_seq.sv
// 3x3 determinant by row-0 cofactor expansion, time-sharing one det2 across
// the three minors and accumulating pivot * signed minor over three cycles.
module det3_seq
    import det_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [35:0]      mat,
    output logic             busy,
    output logic             done,
    output logic [MAG_W-1:0] det_mag,
    output logic             det_sign
);

    state_t state_q, state_d;

    logic [35:0]        mat_q;
    logic [ACC_W-1:0]   acc_q;
    logic [MAG_W-1:0]   det_mag_q;
    logic               det_sign_q;
    logic               done_q;

    logic [ENTRY_W-1:0] op_a, op_b, op_c, op_d, pivot;
    logic               cof_neg;
    logic [7:0]         minor_mag;
    logic               minor_sign;
    logic               eff_neg;
    logic [11:0]        prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_abs;

    // Handshake: start is only looked at in IDLE; busy covers MIN0..FIN and
    // done is a single-cycle pulse coinciding with fresh det_mag/det_sign.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        op_a    = '0;
        op_b    = '0;
        op_c    = '0;
        op_d    = '0;
        pivot   = '0;
        cof_neg = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = MIN0;
            end
            MIN0: begin
                busy    = 1'b1;
                op_a    = mat_q[entry_idx(1, 1) +: ENTRY_W];
                op_b    = mat_q[entry_idx(1, 2) +: ENTRY_W];
                op_c    = mat_q[entry_idx(2, 1) +: ENTRY_W];
                op_d    = mat_q[entry_idx(2, 2) +: ENTRY_W];
                pivot   = mat_q[entry_idx(0, 0) +: ENTRY_W];
                cof_neg = COF_NEG[0];
                state_d = MIN1;
            end
            MIN1: begin
                busy    = 1'b1;
                op_a    = mat_q[entry_idx(1, 0) +: ENTRY_W];
                op_b    = mat_q[entry_idx(1, 2) +: ENTRY_W];
                op_c    = mat_q[entry_idx(2, 0) +: ENTRY_W];
                op_d    = mat_q[entry_idx(2, 2) +: ENTRY_W];
                pivot   = mat_q[entry_idx(0, 1) +: ENTRY_W];
                cof_neg = COF_NEG[1];
                state_d = MIN2;
            end
            MIN2: begin
                busy    = 1'b1;
                op_a    = mat_q[entry_idx(1, 0) +: ENTRY_W];
                op_b    = mat_q[entry_idx(1, 1) +: ENTRY_W];
                op_c    = mat_q[entry_idx(2, 0) +: ENTRY_W];
                op_d    = mat_q[entry_idx(2, 1) +: ENTRY_W];
                pivot   = mat_q[entry_idx(0, 2) +: ENTRY_W];
                cof_neg = COF_NEG[2];
                state_d = FIN;
            end
            FIN: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    det2 u_det2 (
        .a0(op_a[0]), .a1(op_a[1]), .a2(op_a[2]), .a3(op_a[3]),
        .b0(op_b[0]), .b1(op_b[1]), .b2(op_b[2]), .b3(op_b[3]),
        .c0(op_c[0]), .c1(op_c[1]), .c2(op_c[2]), .c3(op_c[3]),
        .d0(op_d[0]), .d1(op_d[1]), .d2(op_d[2]), .d3(op_d[3]),
        .out1(minor_mag[0]), .out2(minor_mag[1]), .out3(minor_mag[2]),
        .out4(minor_mag[3]), .out5(minor_mag[4]), .out6(minor_mag[5]),
        .out7(minor_mag[6]), .out8(minor_mag[7]),
        .sign(minor_sign)
    );

    assign eff_neg  = minor_sign ^ cof_neg;
    assign prod     = {8'b0, pivot} * {4'b0, minor_mag};
    assign prod_ext = {{(ACC_W-12){1'b0}}, prod};
    // A zero accumulator has a clear top bit, so the sign output is 0 for it.
    assign acc_abs  = acc_q[ACC_W-1] ? ({ACC_W{1'b0}} - acc_q) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mat_q      <= '0;
            acc_q      <= '0;
            det_mag_q  <= '0;
            det_sign_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIN);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mat_q <= mat;
                        acc_q <= '0;
                    end
                end
                MIN0, MIN1, MIN2: begin
                    acc_q <= eff_neg ? (acc_q - prod_ext) : (acc_q + prod_ext);
                end
                FIN: begin
                    det_mag_q  <= acc_abs[MAG_W-1:0];
                    det_sign_q <= acc_q[ACC_W-1];
                end
                default: ;
            endcase
        end
    end

    assign done     = done_q;
    assign det_mag  = det_mag_q;
    assign det_sign = det_sign_q;

endmodule

// File: tb/tb_det3_seq.sv
// Bench for det3_seq: directed cases from the test plan plus random matrices,
// checked against a direct integer determinant model.
module tb_det3_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [35:0] mat;
    logic        busy;
    logic        done;
    logic [13:0] det_mag;
    logic        det_sign;

    int total = 0;
    int bad   = 0;

    det3_seq dut (
        .clk(clk), .rst(rst), .start(start), .mat(mat),
        .busy(busy), .done(done), .det_mag(det_mag), .det_sign(det_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] pack9(input int e00, input int e01, input int e02,
                                          input int e10, input int e11, input int e12,
                                          input int e20, input int e21, input int e22);
        int v[9];
        logic [35:0] m;
        v = '{e00, e01, e02, e10, e11, e12, e20, e21, e22};
        m = '0;
        for (int i = 0; i < 9; i++) m[4*i +: 4] = v[i][3:0];
        return m;
    endfunction

    // Plain rule-of-Sarrus determinant on integers.
    function automatic int det_ref(input logic [35:0] m);
        int e[3][3];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                e[r][c] = int'(m[4*(3*r+c) +: 4]);
        return e[0][0]*e[1][1]*e[2][2] + e[0][1]*e[1][2]*e[2][0] + e[0][2]*e[1][0]*e[2][1]
             - e[0][2]*e[1][1]*e[2][0] - e[0][0]*e[1][2]*e[2][1] - e[0][1]*e[1][0]*e[2][2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One computation: start pulsed for a single edge, then wait for done.
    task automatic run_one(input string tag, input logic [35:0] m);
        int d, edges, busy_cnt;
        bit got;
        d = det_ref(m);
        mat = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && edges < 12) begin
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cnt++;
                tick();
                edges++;
            end
        end
        check({tag, " done_seen"}, int'(got), 1);
        if (got) begin
            check({tag, " latency"}, edges, 5);
            check({tag, " busy_cycles"}, busy_cnt, 4);
            check({tag, " mag"}, int'(det_mag), (d < 0) ? -d : d);
            check({tag, " sign"}, int'(det_sign), (d < 0) ? 1 : 0);
            tick();
            check({tag, " done_one_cycle"}, int'(done), 0);
        end
    endtask

    initial begin
        int dones, done_at[$], mag_at[$];
        logic [35:0] m;

        rst = 1'b1;
        start = 1'b0;
        mat = '0;
        tick();
        tick();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset mag", int'(det_mag), 0);
        check("reset sign", int'(det_sign), 0);
        rst = 1'b0;
        tick();

        run_one("identity", pack9(1,0,0, 0,1,0, 0,0,1));
        run_one("upper15", pack9(15,15,15, 0,15,15, 0,0,15));
        run_one("swapped15", pack9(0,15,15, 15,15,15, 0,0,15));
        run_one("singular", pack9(2,0,1, 1,3,2, 1,1,1));
        run_one("offdiag15", pack9(0,15,15, 15,0,15, 15,15,0));
        run_one("neg_corner", pack9(0,0,15, 0,15,0, 15,0,0));

        for (int i = 0; i < 30; i++) begin
            m = {$urandom, $urandom_range(15, 0)};
            if (i % 5 == 0) m[4*$urandom_range(8, 0) +: 4] = 4'd15;
            run_one("random", m);
        end

        // Capture and ignore: mat changes and start pulses during MIN1.
        mat = pack9(1,0,0, 0,1,0, 0,0,1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mat = pack9(7,3,9, 2,5,11, 13,4,6);
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                check("capture mag", int'(det_mag), 1);
                check("capture sign", int'(det_sign), 0);
            end
            tick();
        end
        check("capture done_count", dones, 1);
        check("capture idle_after", int'(busy), 0);

        // Reset during MIN2 aborts; the old result must be wiped, not replaced.
        mat = pack9(3,0,0, 0,3,0, 0,0,3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort in_flight", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort mag", int'(det_mag), 0);
        check("abort sign", int'(det_sign), 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort no_done", dones, 0);

        // Back-to-back with start held: the second matrix is captured at edge 6.
        mat = pack9(2,0,0, 0,2,0, 0,0,2);
        start = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 1) mat = pack9(3,0,0, 0,3,0, 0,0,3);
            if (done) begin
                done_at.push_back(e);
                mag_at.push_back(int'(det_mag));
                if (done_at.size() == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b done_count", done_at.size(), 2);
        if (done_at.size() >= 2) begin
            check("b2b first_edge", done_at[0], 5);
            check("b2b second_edge", done_at[1], 10);
            check("b2b first_mag", mag_at[0], 8);
            check("b2b second_mag", mag_at[1], 27);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
